// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Resets the system PLL, waits for a stable lock, then releases NUM_DOMAINS
//   downstream domain resets in order (bit 0 first), one every STAGE_GAP cycles.
//   A lock timeout re-resets the PLL; a lock loss after release re-asserts every
//   domain reset and restarts the whole sequence. Runs on the free-running
//   reference clock, never on a PLL output.
// Ports
//   clk        in   reference clock
//   reset_n    in   synchronous active-low reset
//   pll_locked in   PLL lock indication, asynchronous to clk
//   pll_rst    out  PLL reset, active-high
//   dom_rst_n  out  per-domain resets, active-low, released bit 0 first
//   ready      out  all domains released and lock held
//   retry_cnt  out  lock-timeout retries since reset, saturating at 255
//   loss_cnt   out  lock losses after release, saturating at 255
//                   (present only when PLL_RST_SEQ_LOSS_CNT_EN is defined)
module pll_reset_sequencer #(
  parameter int NUM_DOMAINS   = 3,
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGE_GAP     = 256
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pll_locked,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] dom_rst_n,
  output logic                   ready,
  output logic [7:0]             retry_cnt
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0]             loss_cnt
`endif
);

  localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_T);

  // Reload values: a state lasting N cycles loads N-1 and leaves when cnt hits 0.
  localparam logic [CW-1:0] RST_LOAD    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TOUT_LOAD   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LOAD = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD    = CW'(STAGE_GAP - 1);

  localparam logic [2:0] S_PLL_RESET = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RELEASE   = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;

  logic                   r_lk_s1;
  logic                   r_lk_s;
  logic [2:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_pll_rst;
  logic [NUM_DOMAINS-1:0] r_dom_rst_n;
  logic                   r_ready;
  logic [7:0]             r_retry_cnt;
  logic [7:0]             r_loss_cnt;
  logic                   w_cnt_zero;
  logic                   w_all_released;
  logic [NUM_DOMAINS-1:0] w_dom_next;

  assign w_cnt_zero     = (r_cnt == '0);
  assign w_all_released = &r_dom_rst_n;
  // Thermometer shift: releases exactly the next bit, so order is structural.
  assign w_dom_next     = (r_dom_rst_n << 1) | NUM_DOMAINS'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lk_s1     <= 1'b0;
      r_lk_s      <= 1'b0;
      r_state     <= S_PLL_RESET;
      // Reset enters PLL_RESET, so the counter takes that state's reload value.
      r_cnt       <= RST_LOAD;
      r_pll_rst   <= 1'b1;
      r_dom_rst_n <= '0;
      r_ready     <= 1'b0;
      r_retry_cnt <= 8'd0;
      r_loss_cnt  <= 8'd0;
    end else begin
      r_lk_s1 <= pll_locked;
      r_lk_s  <= r_lk_s1;
      case (r_state)
        S_PLL_RESET: begin
          if (w_cnt_zero) begin
            r_state   <= S_WAIT_LOCK;
            r_cnt     <= TOUT_LOAD;
            r_pll_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (r_lk_s) begin
            r_state <= S_STABLE;
            r_cnt   <= STABLE_LOAD;
          end else if (w_cnt_zero) begin
            r_state   <= S_PLL_RESET;
            r_cnt     <= RST_LOAD;
            r_pll_rst <= 1'b1;
            if (r_retry_cnt != 8'hff) r_retry_cnt <= r_retry_cnt + 8'd1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_STABLE: begin
          if (!r_lk_s) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= TOUT_LOAD;
          end else if (w_cnt_zero) begin
            r_state <= S_RELEASE;
            // Zero so bit 0 releases on the first RELEASE edge.
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RELEASE, S_RUN: begin
          if (!r_lk_s) begin
            r_state     <= S_PLL_RESET;
            r_cnt       <= RST_LOAD;
            r_pll_rst   <= 1'b1;
            r_dom_rst_n <= '0;
            r_ready     <= 1'b0;
            if (r_loss_cnt != 8'hff) r_loss_cnt <= r_loss_cnt + 8'd1;
          end else if (r_state == S_RELEASE) begin
            if (w_all_released) begin
              r_state <= S_RUN;
              r_ready <= 1'b1;
            end else if (w_cnt_zero) begin
              r_dom_rst_n <= w_dom_next;
              r_cnt       <= GAP_LOAD;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        default: begin
          r_state     <= S_PLL_RESET;
          r_cnt       <= RST_LOAD;
          r_pll_rst   <= 1'b1;
          r_dom_rst_n <= '0;
          r_ready     <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst   = r_pll_rst;
  assign dom_rst_n = r_dom_rst_n;
  assign ready     = r_ready;
  assign retry_cnt = r_retry_cnt;

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  assign loss_cnt = r_loss_cnt;
`else
  logic w_loss_unused;
  assign w_loss_unused = ^r_loss_cnt;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       pll_rst;
  logic [2:0] dom_rst_n;
  logic       ready;
  logic [7:0] retry_cnt;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pll_reset_sequencer #(
    .NUM_DOMAINS  (3),
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (32),
    .STABLE_CYCLES(8),
    .STAGE_GAP    (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .dom_rst_n (dom_rst_n),
    .ready     (ready),
    .retry_cnt (retry_cnt)
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    ,
    .loss_cnt  (loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       locked;
    logic       exp_pll_rst;
    logic [2:0] exp_dom;
    logic       exp_ready;
  } vec_t;

  vec_t vecs[27];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset(input logic locked);
    pll_locked = locked;
    reset_n    = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  // Waits for a DUT condition with a cycle budget; a timeout is a failed check.
  task automatic wait_dom(input logic [2:0] val, input string name);
    int n = 0;
    while (dom_rst_n != val && n < 300) begin
      tick();
      n++;
    end
    chk(name, int'(dom_rst_n), int'(val));
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 300) begin
      tick();
      n++;
    end
    chk(name, int'(ready), 1);
  endtask

  initial begin
    localparam int K = 8;  // vector whose edge first samples pll_locked=1
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    @(negedge clk);

    // Tests 1/2: power-up, PLL reset pulse, then ordered release.
    for (int i = 0; i < 27; i++) begin
      vecs[i].rst_n       = (i >= 3);
      vecs[i].locked      = (i >= K);
      vecs[i].exp_pll_rst = (i <= 5);
      vecs[i].exp_dom     = (i >= K + 15) ? 3'b111 :
                            (i >= K + 13) ? 3'b011 :
                            (i >= K + 11) ? 3'b001 : 3'b000;
      vecs[i].exp_ready   = (i >= K + 16);
    end
    for (int i = 0; i < 27; i++) begin
      reset_n    = vecs[i].rst_n;
      pll_locked = vecs[i].locked;
      tick();
      chk($sformatf("seq%0d_pll_rst", i), int'(pll_rst), int'(vecs[i].exp_pll_rst));
      chk($sformatf("seq%0d_dom", i), int'(dom_rst_n), int'(vecs[i].exp_dom));
      chk($sformatf("seq%0d_ready", i), int'(ready), int'(vecs[i].exp_ready));
    end
    chk("seq_retry", int'(retry_cnt), 0);

    // Test 5: lock loss in RUN.
    pll_locked = 1'b0;
    tick();
    tick();
    chk("loss_ready_hold", int'(ready), 1);
    tick();
    chk("loss_dom", int'(dom_rst_n), 0);
    chk("loss_ready", int'(ready), 0);
    chk("loss_pll_rst", int'(pll_rst), 1);
    chk("loss_retry", int'(retry_cnt), 0);
    pll_locked = 1'b1;
    wait_ready("loss_rerun_ready");
    chk("loss_rerun_dom", int'(dom_rst_n), 7);
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    chk("loss_cnt", int'(loss_cnt), 1);
`endif

    // Test 4: one-cycle lock glitch in STABLE restarts the stable count.
    do_reset(1'b0);
    repeat (4) tick();
    chk("glitch_pll_rst_low", int'(pll_rst), 0);
    pll_locked = 1'b1;
    repeat (4) tick();       // edges k .. k+3
    pll_locked = 1'b0;
    tick();                  // edge g = k+4
    pll_locked = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      tick();
      chk($sformatf("glitch_hold%0d", j), int'(dom_rst_n), 0);
    end
    tick();
    chk("glitch_release", int'(dom_rst_n), 1);

    // Test 3: no lock; PLL re-pulsed every 36 cycles, retry_cnt saturates.
    do_reset(1'b0);
    for (int e = 1; e <= 36 * 258 + 4; e++) begin
      tick();
      chk($sformatf("retry_pll_rst_e%0d", e), int'(pll_rst), int'((e % 36) <= 3));
      chk($sformatf("retry_cnt_e%0d", e), int'(retry_cnt), ((e / 36) > 255) ? 255 : (e / 36));
      chk($sformatf("retry_dom_e%0d", e), int'(dom_rst_n), 0);
    end

    // Test 6: reset_n during RELEASE with dom_rst_n=011.
    pll_locked = 1'b1;
    wait_dom(3'b011, "mid_release_dom");
    reset_n = 1'b0;
    tick();
    chk("mid_rst_pll_rst", int'(pll_rst), 1);
    chk("mid_rst_dom", int'(dom_rst_n), 0);
    chk("mid_rst_ready", int'(ready), 0);
    chk("mid_rst_retry", int'(retry_cnt), 0);
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    chk("mid_rst_loss_cnt", int'(loss_cnt), 0);
`endif
    reset_n = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("mid_restart_pll_rst_e%0d", e), int'(pll_rst), int'(e <= 3));
      chk($sformatf("mid_restart_dom_e%0d", e), int'(dom_rst_n), 0);
    end
    wait_ready("mid_restart_ready");
    chk("mid_restart_dom", int'(dom_rst_n), 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
